instr_sequencer: RTL

//  Multi-cycle control FSM sequencing the core: fetch -> decode -> execute -> memory -> writeback.

---
 rtl/instr_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Owns PC and IR, handshakes with both memories and strobes the datapath.
module instr_sequencer #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 255,
   parameter int              TO_W     = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   output logic [31:0]     ir_o,
   input  logic [2:0]      dec_class_i,
   input  logic            branch_taken_i,
   input  logic [PC_W-1:0] target_pc_i,
   output logic            alu_en_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   input  logic            dmem_ack_i,
   output logic            rf_we_o,
   output logic [PC_W-1:0] pc_o,
   output logic [2:0]      state_o,
   output logic            busy_o,
   output logic            err_o,
   output logic [31:0]     instr_count_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_e;

   localparam logic [2:0]      CLS_ALU    = 3'd0;
   localparam logic [2:0]      CLS_LOAD   = 3'd1;
   localparam logic [2:0]      CLS_STORE  = 3'd2;
   localparam logic [2:0]      CLS_BRANCH = 3'd3;
   localparam logic [2:0]      CLS_JUMP   = 3'd4;
   localparam logic [2:0]      CLS_HALT   = 3'd5;
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d, pc_inc_s;
   logic [31:0]       ir_q, ir_d;
   logic [2:0]        cls_q, cls_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              timeout_s;
   logic              imem_req_q, imem_req_d;
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic              alu_en_q, alu_en_d;
   logic              rf_we_q, rf_we_d;
   logic              busy_q, busy_d;

   assign pc_inc_s  = pc_q + PC_W'(4);
   assign timeout_s = (to_q == TO_LAST);

   // Next-state, PC/IR/count updates and wait-cycle timeout.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cls_d   = cls_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      to_d    = to_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start_i) state_d = S_FETCH;
            else         state_d = state_q;
         end
         S_FETCH: begin
            if (imem_ack_i && imem_req_q) begin
               ir_d    = imem_rdata_i;
               state_d = S_DECODE;
            end else if (timeout_s) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_DECODE: begin
            cls_d = dec_class_i;
            case (dec_class_i)
               CLS_HALT: begin
                  pc_d    = pc_inc_s;
                  cnt_d   = cnt_q + 32'd1;
                  state_d = S_HALT;
               end
               3'd6, 3'd7: begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               CLS_ALU:             state_d = S_WB;
               CLS_LOAD, CLS_STORE: state_d = S_MEM;
               CLS_BRANCH: begin
                  pc_d    = branch_taken_i ? target_pc_i : pc_inc_s;
                  cnt_d   = cnt_q + 32'd1;
                  state_d = S_FETCH;
               end
               CLS_JUMP: begin
                  pc_d    = target_pc_i;
                  cnt_d   = cnt_q + 32'd1;
                  state_d = S_FETCH;
               end
               default: begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (dmem_ack_i && dmem_req_q) begin
               if (cls_q == CLS_STORE) begin
                  pc_d    = pc_inc_s;
                  cnt_d   = cnt_q + 32'd1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_s) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_WB: begin
            pc_d    = pc_inc_s;
            cnt_d   = cnt_q + 32'd1;
            state_d = S_FETCH;
         end
         S_ERROR: state_d = S_ERROR;
         default: begin
            state_d = S_ERROR;
            err_d   = 1'b1;
         end
      endcase
      // Every wait phase starts counting from zero.
      if (state_d != state_q) to_d = '0;
      else                    to_d = to_d;
   end

   // Moore strobes computed from the next state so they are registered with it.
   always_comb begin
      imem_req_d = (state_d == S_FETCH);
      dmem_req_d = (state_d == S_MEM);
      dmem_we_d  = (state_d == S_MEM) && (cls_d == CLS_STORE);
      alu_en_d   = (state_d == S_EXEC);
      rf_we_d    = (state_d == S_WB);
      busy_d     = (state_d != S_IDLE) && (state_d != S_HALT) && (state_d != S_ERROR);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 32'd0;
         cls_q      <= 3'd0;
         cnt_q      <= 32'd0;
         err_q      <= 1'b0;
         to_q       <= '0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         alu_en_q   <= 1'b0;
         rf_we_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         cls_q      <= cls_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         to_q       <= to_d;
         imem_req_q <= imem_req_d;
         dmem_req_q <= dmem_req_d;
         dmem_we_q  <= dmem_we_d;
         alu_en_q   <= alu_en_d;
         rf_we_q    <= rf_we_d;
         busy_q     <= busy_d;
      end
   end

   assign imem_req_o    = imem_req_q;
   assign imem_addr_o   = pc_q;
   assign ir_o          = ir_q;
   assign alu_en_o      = alu_en_q;
   assign dmem_req_o    = dmem_req_q;
   assign dmem_we_o     = dmem_we_q;
   assign rf_we_o       = rf_we_q;
   assign pc_o          = pc_q;
   assign state_o       = state_q;
   assign busy_o        = busy_q;
   assign err_o         = err_q;
   assign instr_count_o = cnt_q;

endmodule
